// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO geometry and count-width helper
package fifo_pkg;
  localparam int def_data_width = 10;
  localparam int def_data_depth = 16;
  localparam int def_addr_width = 4;
  function automatic int count_width(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: dual-port storage array, synchronous write, registered read cleared by reset
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int data_width = def_data_width,
  parameter int addr_width = def_addr_width
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic                  re,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);
  logic [data_width-1:0] mem [2**addr_width];
  // storage is never cleared, only overwritten
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register holds its value unless a read is accepted
  always_ff @(posedge clk)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fifo.sv
// fifo: single-clock FIFO with registered read data and full/empty flags; FIFO_COUNT_EN adds data_count
module fifo
  import fifo_pkg::*;
#(
  parameter int data_width = def_data_width,
  parameter int data_depth = def_data_depth,
  parameter int addr_width = def_addr_width
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_en,
  output logic [data_width-1:0] rd_data,
  output logic                  full,
  output logic                  empty
`ifdef FIFO_COUNT_EN
  ,
  output logic [addr_width:0]   data_count
`endif
);
  localparam int cw = count_width(addr_width);
  logic [addr_width-1:0] wr_ptr, rd_ptr;
  logic [cw-1:0] count;
  logic wr_ok, rd_ok;
  assign full  = count == cw'(data_depth);
  assign empty = count == '0;
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
`ifdef FIFO_COUNT_EN
  assign data_count = count;
`endif
  // pointers and occupancy advance on accepted operations; reset discards all stored data
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ok ? addr_width'(wr_ptr + 1) : wr_ptr;
      rd_ptr <= rd_ok ? addr_width'(rd_ptr + 1) : rd_ptr;
      count  <= count + cw'(wr_ok) - cw'(rd_ok);
    end
  fifo_mem #(.data_width(data_width), .addr_width(addr_width)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok && rst_n),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: vector table plus queue-model scoreboard for fifo
module tb_fifo;
  logic clk = 0, rst_n = 0, wr_en = 0, rd_en = 0;
  logic [9:0] wr_data = '0, rd_data;
  logic full, empty;
`ifdef FIFO_COUNT_EN
  logic [4:0] data_count;
`endif
  int vectors = 0, miscompares = 0;
  logic [9:0] mq[$];
  logic [9:0] exp_q[$];
  logic [9:0] mrd = '0;
  typedef struct {
    logic rn, w, r;
    logic [9:0] d;
    logic e, f;
    logic [9:0] rd;
  } vec_t;
  vec_t tbl[15];

  fifo dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .full(full), .empty(empty)
`ifdef FIFO_COUNT_EN
    , .data_count(data_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rn, input logic w, input logic r, input logic [9:0] d);
    bit acc_r, acc_w;
    @(negedge clk);
    rst_n = rn; wr_en = w; rd_en = r; wr_data = d;
    acc_r = r && mq.size() != 0;
    acc_w = w && (mq.size() != 16 || acc_r);
    if (!rn) begin
      mq.delete(); exp_q.delete(); mrd = '0;
    end else begin
      if (acc_r) exp_q.push_back(mq.pop_front());
      if (acc_w) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    if (rn && acc_r) mrd = exp_q.pop_front();
    chk("rd_data", rd_data, mrd);
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == 16);
`ifdef FIFO_COUNT_EN
    chk("data_count", data_count, mq.size());
`endif
  endtask

  initial begin
    tbl[0] = '{rn: 0, w: 0, r: 0, d: 0, e: 1, f: 0, rd: 0};
    tbl[1] = '{rn: 1, w: 0, r: 1, d: 0, e: 1, f: 0, rd: 0};
    for (int i = 0; i < 10; i++) tbl[2+i] = '{rn: 1, w: 1, r: 0, d: 10'(i), e: 0, f: 0, rd: 0};
    for (int i = 0; i < 3; i++) tbl[12+i] = '{rn: 1, w: 0, r: 1, d: 0, e: 0, f: 0, rd: 10'(i)};
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rn, tbl[i].w, tbl[i].r, tbl[i].d);
      chk("tbl_rd", rd_data, tbl[i].rd);
      chk("tbl_empty", empty, tbl[i].e);
      chk("tbl_full", full, tbl[i].f);
    end
`ifdef FIFO_COUNT_EN
    chk("count_7", data_count, 7);
`endif
    step(1, 1, 0, 88); step(1, 1, 0, 11); step(1, 1, 0, 12);
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0);
    chk("drain_last", rd_data, 12);
    chk("drain_empty", empty, 1);
    step(1, 0, 1, 0);
    chk("hold_12", rd_data, 12);
    for (int i = 0; i < 16; i++) step(1, 1, 0, 10'(100 + i));
    chk("fill_full", full, 1);
    step(1, 1, 0, 200);
    chk("drop_full", full, 1);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 1, 0);
      chk("fill_order", rd_data, 100 + i);
    end
    chk("fill_empty", empty, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 10'(300 + i));
    step(1, 1, 1, 33);
    chk("sim_rd", rd_data, 300);
`ifdef FIFO_COUNT_EN
    chk("sim_count", data_count, 5);
`endif
    for (int i = 0; i < 11; i++) step(1, 1, 0, 10'(400 + i));
    chk("sim_full_pre", full, 1);
    step(1, 1, 1, 500);
    chk("sim_full_rd", rd_data, 301);
    chk("sim_full_flag", full, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 1, 0);
    chk("sim_last", rd_data, 500);
    for (int i = 0; i < 40; i++) step(1, (i % 4) != 3, (i % 3) != 0, 10'(600 + i));
    step(1, 1, 0, 7); step(1, 1, 0, 8);
    step(0, 1, 1, 9);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_rd", rd_data, 0);
    step(1, 0, 1, 0);
    chk("post_rst_hold", rd_data, 0);
    step(1, 1, 0, 55);
    step(1, 0, 1, 0);
    chk("post_rst_data", rd_data, 55);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
